// File: rtl/ucode_loader_pkg.sv
// ucode_loader_pkg
//   Shared types and constants for the microcode loader:
//   instruction_t   - one instruction-memory word (24 bits)
//   im_addr_t       - instruction-memory row index (default 4 bits)
//   loader_state_e  - loader FSM state encoding
//   nchunk()        - stream words needed per instruction for a chunk width
//   NCHUNK          - nchunk() at the default 8-bit chunk width
package ucode_loader_pkg;

  localparam int INSTR_WIDTH = 24;
  typedef logic [INSTR_WIDTH-1:0] instruction_t;

  localparam int IM_ADDR_W = 4;
  typedef logic [IM_ADDR_W-1:0] im_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_e;

  // Ceiling division: a partial last chunk still costs a whole transfer.
  function automatic int nchunk(input int chunk_width);
    return (INSTR_WIDTH + chunk_width - 1) / chunk_width;
  endfunction

  localparam int NCHUNK = nchunk(8);

endpackage

// File: rtl/ucode_loader_if.sv
// ucode_loader_if
//   Valid/ready chunk stream carrying instruction words in pieces.
//   valid - source has a word on data
//   data  - CHUNK_WIDTH-bit stream word, least significant chunk first
//   ready - sink accepts the word this cycle
//   modport master: stream source; modport slave: stream sink.
interface ucode_loader_if #(
  parameter int CHUNK_WIDTH = 8
);
  logic                   valid;
  logic [CHUNK_WIDTH-1:0] data;
  logic                   ready;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/ucode_chunk_assembler.sv
// ucode_chunk_assembler
//   Packs NCHUNK stream words into one instruction, chunk k landing at
//   bits [k*CHUNK_WIDTH +: CHUNK_WIDTH]; bits above the instruction width
//   are dropped.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   chunk          - stream sink (ready = collect_i)
//   collect_i      - loader is collecting; opens the stream
//   clear_i        - drop any partial instruction (dominates a transfer)
//   word_done_o    - this cycle's transfer completes the instruction
//   word_o         - assembled instruction
module ucode_chunk_assembler
  import ucode_loader_pkg::*;
#(
  parameter int CHUNK_WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ucode_loader_if.slave chunk,
  input  logic         collect_i,
  input  logic         clear_i,
  output logic         word_done_o,
  output instruction_t word_o
);

  localparam int NCH   = nchunk(CHUNK_WIDTH);
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [NCH*CHUNK_WIDTH-1:0] asm_q, asm_d;
  logic                       fire;

  // Ready is purely a function of state, never of valid.
  assign chunk.ready = collect_i;
  assign fire        = chunk.valid && collect_i && !clear_i;
  assign word_o      = asm_q[INSTR_WIDTH-1:0];

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    word_done_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (fire) begin
      for (int k = 0; k < NCH; k++) begin
        if (cnt_q == CNT_W'(k)) asm_d[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk.data;
      end
      if (cnt_q == CNT_W'(NCH - 1)) begin
        cnt_d       = '0;
        word_done_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: the assembly register is reset too, so im_data_o reads 0 out of
  // reset instead of stale data; it is a single register, not a RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge value regardless of block ordering.
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/ucode_loader.sv
// ucode_loader
//   Streams instructions in as CHUNK_WIDTH-bit pieces and writes them to
//   consecutive instruction-memory rows starting at base_addr_i, wrapping
//   modulo 2**IM_ADDR_WIDTH.
//   Control: start_i (IDLE only), abort_i (highest priority), busy_o,
//            done_o (one-cycle pulse, the cycle after the DONE state)
//   Stream:  chunk_valid_i / chunk_data_i / chunk_ready_o
//   Memory:  im_we_o / im_addr_o / im_data_o
//   Build option: define UCODE_LOADER_CHECKSUM_EN to keep a running XOR of
//   written instructions on checksum_o (cleared on start); otherwise 0.
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int IM_ADDR_WIDTH = 4,
  parameter int CHUNK_WIDTH   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [IM_ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [IM_ADDR_WIDTH:0]       count_i,
  input  logic                         chunk_valid_i,
  input  logic [CHUNK_WIDTH-1:0]       chunk_data_i,
  output logic                         chunk_ready_o,
  output logic                         im_we_o,
  output logic [IM_ADDR_WIDTH-1:0]     im_addr_o,
  output instruction_t                 im_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$bits(instruction_t)-1:0] checksum_o
);

  loader_state_e              state_q, state_d;
  logic [IM_ADDR_WIDTH-1:0]   row_q, row_d;
  logic [IM_ADDR_WIDTH:0]     remain_q, remain_d;
  logic                       done_q, done_d;
  logic                       collect, word_done, start_accept;

  ucode_loader_if #(.CHUNK_WIDTH(CHUNK_WIDTH)) chunk_if ();

  assign chunk_if.valid = chunk_valid_i;
  assign chunk_if.data  = chunk_data_i;
  assign chunk_ready_o  = chunk_if.ready;
  assign collect        = (state_q == COLLECT);

  ucode_chunk_assembler #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .chunk       (chunk_if),
    .collect_i   (collect),
    .clear_i     (abort_i),
    .word_done_o (word_done),
    .word_o      (im_data_o)
  );

  assign im_addr_o = row_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    remain_d     = remain_q;
    done_d       = 1'b0;
    im_we_o      = 1'b0;
    start_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          start_accept = 1'b1;
          row_d        = base_addr_i;
          remain_d     = count_i;
          state_d      = (count_i != '0) ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        if (abort_i)        state_d = IDLE;
        else if (word_done) state_d = WRITE;
      end
      WRITE: begin
        // An abort here suppresses the write that is already presented.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          im_we_o  = 1'b1;
          row_d    = row_q + 1'b1;
          remain_d = remain_q - 1'b1;
          state_d  = (remain_q == (IM_ADDR_WIDTH+1)'(1)) ? DONE : COLLECT;
        end
      end
      DONE: begin
        done_d  = !abort_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      row_q    <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

`ifdef UCODE_LOADER_CHECKSUM_EN
  instruction_t checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) checksum_d = '0;
    if (im_we_o)      checksum_d = checksum_q ^ im_data_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`else
  logic unused_start_accept;
  assign unused_start_accept = start_accept;
  assign checksum_o          = '0;
`endif

endmodule
